// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes and FSM state encoding for the MEM-stage LSU
// Purpose: constants and types used by mem_lsu and lsu_align.
package lsu_pkg;

   // RV32I load/store size/sign encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane steering, load extension and legality check
// Purpose: maps an access onto a 32-bit word bus.
// Ports:
//   i_load/i_store            current access kind (for the legality check)
//   i_funct3/i_offset/i_wsrc  current access size, byte offset and store data
//   o_be/o_wdata              store byte enables and lane-replicated store data
//   o_legal                   access is aligned, has a valid funct3, and is not both load and store
//   i_ld_funct3/i_ld_offset   size and offset captured when the load was issued
//   i_rdata/o_ldata           raw bus word in, extended load result out
module lsu_align
   import lsu_pkg::*;
(
   input  logic        i_load,
   input  logic        i_store,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_wsrc,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_legal,
   input  logic [2:0]  i_ld_funct3,
   input  logic [1:0]  i_ld_offset,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_ldata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Store lanes: data is replicated so the selected lanes always carry it
   always_comb begin
      o_be    = 4'b0000;
      o_wdata = 32'd0;
      case (i_funct3)
         F3_B: begin
            o_be    = 4'b0001 << i_offset;
            o_wdata = {4{i_wsrc[7:0]}};
         end
         F3_H: begin
            o_be    = 4'b0011 << i_offset;
            o_wdata = {2{i_wsrc[15:0]}};
         end
         F3_W: begin
            o_be    = 4'b1111;
            o_wdata = i_wsrc;
         end
         default: ;
      endcase
   end

   always_comb begin
      o_legal = 1'b0;
      if (i_load && !i_store) begin
         case (i_funct3)
            F3_B, F3_BU: o_legal = 1'b1;
            F3_H, F3_HU: o_legal = ~i_offset[0];
            F3_W:        o_legal = (i_offset == 2'b00);
            default:     o_legal = 1'b0;
         endcase
      end else if (i_store && !i_load) begin
         case (i_funct3)
            F3_B:    o_legal = 1'b1;
            F3_H:    o_legal = ~i_offset[0];
            F3_W:    o_legal = (i_offset == 2'b00);
            default: o_legal = 1'b0;
         endcase
      end
   end

   assign w_byte = i_rdata[{i_ld_offset, 3'b000} +: 8];
   assign w_half = i_ld_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      case (i_ld_funct3)
         F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_ldata = {24'd0, w_byte};
         F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
         F3_HU:   o_ldata = {16'd0, w_half};
         default: o_ldata = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with request/ready data-memory bus
// Purpose: issues one word-aligned, byte-enabled bus access per memory instruction,
//   stalls the pipeline until it completes and returns the extended load data.
// Optional feature macro: LSU_TIMEOUT_EN (abort after TIMEOUT BUSY cycles without dmem_ready).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   MemRead_MEM/MemWrite_MEM  access request from EX/MEM
//   funct3_MEM, aluout_MEM    size/sign and byte address
//   rs2data_MEM               store data
//   dataout_MEM               extended load result to MEM/WB
//   stall_MEM                 freeze upstream pipeline registers
//   misalign_MEM              misaligned/illegal access, suppressed
//   dmem_*                    data-memory bus (req/we/addr/be/wdata out, ready/rdata in)
//   bus_err_MEM               one-cycle timeout abort flag
module mem_lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int TW      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead_MEM,
   input  logic        MemWrite_MEM,
   input  logic [2:0]  funct3_MEM,
   input  logic [31:0] aluout_MEM,
   input  logic [31:0] rs2data_MEM,
   output logic [31:0] dataout_MEM,
   output logic        stall_MEM,
   output logic        misalign_MEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        bus_err_MEM
);

   lsu_state_t  r_state;
   logic        r_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [31:0] r_dout;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;
`ifdef LSU_TIMEOUT_EN
   logic [TW-1:0] r_cnt;
   logic          r_err;
`endif

   logic        w_access;
   logic        w_idle;
   logic        w_legal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ldata;

   assign w_access = MemRead_MEM | MemWrite_MEM;
   assign w_idle   = (r_state == IDLE);

   lsu_align u_align (
      .i_load      (MemRead_MEM),
      .i_store     (MemWrite_MEM),
      .i_funct3    (funct3_MEM),
      .i_offset    (aluout_MEM[1:0]),
      .i_wsrc      (rs2data_MEM),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .o_legal     (w_legal),
      .i_ld_funct3 (r_f3),
      .i_ld_offset (r_off),
      .i_rdata     (dmem_rdata),
      .o_ldata     (w_ldata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_be    <= 4'b0000;
         r_wdata <= 32'd0;
         r_dout  <= 32'd0;
         r_f3    <= 3'b000;
         r_off   <= 2'b00;
`ifdef LSU_TIMEOUT_EN
         r_cnt   <= '0;
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_access && w_legal) begin
                  r_addr  <= {aluout_MEM[31:2], 2'b00};
                  r_be    <= MemWrite_MEM ? w_be : 4'b1111;
                  r_wdata <= MemWrite_MEM ? w_wdata : 32'd0;
                  r_we    <= MemWrite_MEM;
                  r_f3    <= funct3_MEM;
                  r_off   <= aluout_MEM[1:0];
                  r_req   <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
                  r_state <= BUSY;
               end else if (w_access) begin
                  // Suppressed access still writes back a clean zero
                  r_dout <= 32'd0;
               end
            end
            BUSY: begin
               if (dmem_ready) begin
                  if (!r_we) r_dout <= w_ldata;
                  r_req   <= 1'b0;
                  r_state <= DONE;
               end
`ifdef LSU_TIMEOUT_EN
               // Counter holds the number of completed waiting cycles; abort on the last allowed one
               else if (r_cnt == TW'(TIMEOUT - 1)) begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_req   <= 1'b0;
                  r_dout  <= 32'd0;
                  r_err   <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            DONE: begin
`ifdef LSU_TIMEOUT_EN
               r_err <= 1'b0;
`endif
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign misalign_MEM = w_idle & w_access & ~w_legal;
   assign stall_MEM    = (w_idle & w_access & w_legal) | (r_state == BUSY);
   assign dataout_MEM  = misalign_MEM ? 32'd0 : r_dout;
   assign dmem_req     = r_req;
   assign dmem_we      = r_we;
   assign dmem_addr    = r_addr;
   assign dmem_be      = r_be;
   assign dmem_wdata   = r_wdata;
`ifdef LSU_TIMEOUT_EN
   assign bus_err_MEM  = r_err;
`else
   assign bus_err_MEM  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

   logic        clk;
   logic        rst;
   logic        MemRead_MEM;
   logic        MemWrite_MEM;
   logic [2:0]  funct3_MEM;
   logic [31:0] aluout_MEM;
   logic [31:0] rs2data_MEM;
   logic [31:0] dataout_MEM;
   logic        stall_MEM;
   logic        misalign_MEM;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        bus_err_MEM;

   int checks = 0;
   int errors = 0;

   mem_lsu #(.TIMEOUT(15), .TW(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .MemRead_MEM  (MemRead_MEM),
      .MemWrite_MEM (MemWrite_MEM),
      .funct3_MEM   (funct3_MEM),
      .aluout_MEM   (aluout_MEM),
      .rs2data_MEM  (rs2data_MEM),
      .dataout_MEM  (dataout_MEM),
      .stall_MEM    (stall_MEM),
      .misalign_MEM (misalign_MEM),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_ready   (dmem_ready),
      .dmem_rdata   (dmem_rdata),
      .bus_err_MEM  (bus_err_MEM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      MemRead_MEM  = rd;
      MemWrite_MEM = wr;
      funct3_MEM   = f3;
      aluout_MEM   = addr;
      rs2data_MEM  = wd;
   endtask

   task automatic nop();
      drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", dmem_req); end
      checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b exp 0", dmem_we); end
      checks++; if (dmem_be !== 4'b0000) begin errors++; $display("FAIL rst_be: got %b exp 0000", dmem_be); end
      checks++; if (dmem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h exp 0", dmem_addr); end
      checks++; if (dmem_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h exp 0", dmem_wdata); end
      checks++; if (dataout_MEM !== 32'd0) begin errors++; $display("FAIL rst_dout: got %h exp 0", dataout_MEM); end
      checks++; if (bus_err_MEM !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", bus_err_MEM); end
      checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", stall_MEM); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lw();
      @(negedge clk);
      drive(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
      #1;
      checks++; if (stall_MEM !== 1'b1) begin errors++; $display("FAIL lw_stall_c0: got %b exp 1", stall_MEM); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL lw_req_c0: got %b exp 0", dmem_req); end
      @(negedge clk); #1;
      checks++; if (stall_MEM !== 1'b1) begin errors++; $display("FAIL lw_stall_c1: got %b exp 1", stall_MEM); end
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL lw_req_c1: got %b exp 1", dmem_req); end
      checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h exp 00000100", dmem_addr); end
      checks++; if (dmem_be !== 4'b1111) begin errors++; $display("FAIL lw_be: got %b exp 1111", dmem_be); end
      checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL lw_we: got %b exp 0", dmem_we); end
      dmem_ready = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      // ready left high with other data during DONE and the following IDLE must be ignored
      dmem_rdata = 32'h1111_1111;
      nop();
      #1;
      checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL lw_stall_c2: got %b exp 0", stall_MEM); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL lw_req_c2: got %b exp 0", dmem_req); end
      checks++; if (dataout_MEM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_dout: got %h exp deadbeef", dataout_MEM); end
      @(negedge clk);
      dmem_ready = 1'b0;
      #1;
      checks++; if (dataout_MEM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_dout_hold: got %h exp deadbeef", dataout_MEM); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL lw_req_idle: got %b exp 0", dmem_req); end
   endtask

   task automatic test_store();
      logic [2:0]  f3 [3] = '{3'b001, 3'b000, 3'b010};
      logic [31:0] ad [3] = '{32'h0000_0202, 32'h0000_0101, 32'h0000_0204};
      logic [31:0] rs [3] = '{32'h0000_ABCD, 32'h1234_5678, 32'hCAFE_F00D};
      logic [31:0] ea [3] = '{32'h0000_0200, 32'h0000_0100, 32'h0000_0204};
      logic [3:0]  eb [3] = '{4'b1100, 4'b0010, 4'b1111};
      logic [31:0] ew [3] = '{32'hABCD_ABCD, 32'h7878_7878, 32'hCAFE_F00D};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, f3[i], ad[i], rs[i]);
         @(negedge clk); #1;
         checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL st%0d_we: got %b exp 1", i, dmem_we); end
         checks++; if (dmem_addr !== ea[i]) begin errors++; $display("FAIL st%0d_addr: got %h exp %h", i, dmem_addr, ea[i]); end
         checks++; if (dmem_be !== eb[i]) begin errors++; $display("FAIL st%0d_be: got %b exp %b", i, dmem_be, eb[i]); end
         checks++; if (dmem_wdata !== ew[i]) begin errors++; $display("FAIL st%0d_wdata: got %h exp %h", i, dmem_wdata, ew[i]); end
         dmem_ready = 1'b1;
         @(negedge clk);
         dmem_ready = 1'b0;
         nop();
         #1;
         checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL st%0d_stall_done: got %b exp 0", i, stall_MEM); end
         checks++; if (dataout_MEM !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st%0d_dout_hold: got %h exp deadbeef", i, dataout_MEM); end
      end
      @(negedge clk);
   endtask

   task automatic test_misalign();
      logic        rd [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic        wr [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [2:0]  f3 [7] = '{3'b010, 3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
      logic [31:0] ad [7] = '{32'h101, 32'h103, 32'h201, 32'h202, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         drive(rd[i], wr[i], f3[i], ad[i], 32'h5555_5555);
         #1;
         checks++; if (misalign_MEM !== 1'b1) begin errors++; $display("FAIL mis%0d_flag: got %b exp 1", i, misalign_MEM); end
         checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL mis%0d_stall: got %b exp 0", i, stall_MEM); end
         checks++; if (dataout_MEM !== 32'd0) begin errors++; $display("FAIL mis%0d_dout: got %h exp 0", i, dataout_MEM); end
         @(negedge clk); #1;
         checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis%0d_req: got %b exp 0", i, dmem_req); end
         checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL mis%0d_stall2: got %b exp 0", i, stall_MEM); end
      end
      nop();
      #1;
      checks++; if (dataout_MEM !== 32'd0) begin errors++; $display("FAIL mis_dout_after: got %h exp 0", dataout_MEM); end
      checks++; if (misalign_MEM !== 1'b0) begin errors++; $display("FAIL mis_flag_nop: got %b exp 0", misalign_MEM); end
   endtask

   task automatic test_delayed_ready();
      @(negedge clk);
      drive(1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL dly%0d_req: got %b exp 1", i, dmem_req); end
         checks++; if (stall_MEM !== 1'b1) begin errors++; $display("FAIL dly%0d_stall: got %b exp 1", i, stall_MEM); end
         checks++; if (dmem_addr !== 32'd0) begin errors++; $display("FAIL dly%0d_addr: got %h exp 0", i, dmem_addr); end
         checks++; if (dmem_be !== 4'b1000) begin errors++; $display("FAIL dly%0d_be: got %b exp 1000", i, dmem_be); end
         checks++; if (dmem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL dly%0d_wdata: got %h exp a5a5a5a5", i, dmem_wdata); end
      end
      dmem_ready = 1'b1;
      @(negedge clk);
      dmem_ready = 1'b0;
      nop();
      #1;
      checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL dly_stall_done: got %b exp 0", stall_MEM); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL dly_req_done: got %b exp 0", dmem_req); end
      // Second run: reset lands in the middle of BUSY
      @(negedge clk);
      drive(1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5);
      @(negedge clk);
      @(negedge clk); #1;
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_pre: got %b exp 1", dmem_req); end
      rst = 1'b1;
      #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b exp 0", dmem_req); end
      checks++; if (dmem_be !== 4'b0000) begin errors++; $display("FAIL rstmid_be: got %b exp 0000", dmem_be); end
      checks++; if (dmem_wdata !== 32'd0) begin errors++; $display("FAIL rstmid_wdata: got %h exp 0", dmem_wdata); end
      nop();
      #1;
      checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b exp 0", stall_MEM); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req_after: got %b exp 0", dmem_req); end
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
      logic [31:0] ad [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
      logic [31:0] rd [6] = '{32'h80FF_1234, 32'h80FF_1234, 32'h80FF_1234,
                              32'h80FF_1234, 32'h80FF_1234, 32'h1234_F00D};
      logic [31:0] ex [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                              32'h0000_80FF, 32'h0000_0012, 32'hFFFF_F00D};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, f3[i], ad[i], 32'd0);
         @(negedge clk); #1;
         checks++; if (dmem_be !== 4'b1111) begin errors++; $display("FAIL ld%0d_be: got %b exp 1111", i, dmem_be); end
         checks++; if (dmem_addr !== {ad[i][31:2], 2'b00}) begin errors++; $display("FAIL ld%0d_addr: got %h exp %h", i, dmem_addr, {ad[i][31:2], 2'b00}); end
         dmem_ready = 1'b1;
         dmem_rdata = rd[i];
         @(negedge clk);
         dmem_ready = 1'b0;
         dmem_rdata = 32'd0;
         nop();
         #1;
         checks++; if (dataout_MEM !== ex[i]) begin errors++; $display("FAIL ld%0d_dout: got %h exp %h", i, dataout_MEM, ex[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      @(negedge clk);
      drive(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0);
`ifdef LSU_TIMEOUT_EN
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk); #1;
         checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL to%0d_req: got %b exp 1", i, dmem_req); end
         checks++; if (bus_err_MEM !== 1'b0) begin errors++; $display("FAIL to%0d_err: got %b exp 0", i, bus_err_MEM); end
      end
      @(negedge clk);
      nop();
      #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL to_req: got %b exp 0", dmem_req); end
      checks++; if (bus_err_MEM !== 1'b1) begin errors++; $display("FAIL to_err: got %b exp 1", bus_err_MEM); end
      checks++; if (dataout_MEM !== 32'd0) begin errors++; $display("FAIL to_dout: got %h exp 0", dataout_MEM); end
      checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL to_stall: got %b exp 0", stall_MEM); end
      @(negedge clk); #1;
      checks++; if (bus_err_MEM !== 1'b0) begin errors++; $display("FAIL to_err_clr: got %b exp 0", bus_err_MEM); end
`else
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk); #1;
         checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL wait%0d_req: got %b exp 1", i, dmem_req); end
         checks++; if (stall_MEM !== 1'b1) begin errors++; $display("FAIL wait%0d_stall: got %b exp 1", i, stall_MEM); end
         checks++; if (bus_err_MEM !== 1'b0) begin errors++; $display("FAIL wait%0d_err: got %b exp 0", i, bus_err_MEM); end
      end
      dmem_ready = 1'b1;
      dmem_rdata = 32'h5A5A_5A5A;
      @(negedge clk);
      dmem_ready = 1'b0;
      nop();
      #1;
      checks++; if (dataout_MEM !== 32'h5A5A_5A5A) begin errors++; $display("FAIL wait_dout: got %h exp 5a5a5a5a", dataout_MEM); end
      checks++; if (stall_MEM !== 1'b0) begin errors++; $display("FAIL wait_stall: got %b exp 0", stall_MEM); end
      checks++; if (bus_err_MEM !== 1'b0) begin errors++; $display("FAIL wait_err: got %b exp 0", bus_err_MEM); end
      @(negedge clk);
`endif
   endtask

   initial begin
      rst        = 1'b1;
      dmem_ready = 1'b0;
      dmem_rdata = 32'd0;
      nop();
      test_reset();
      test_lw();
      test_store();
      test_misalign();
      test_delayed_ready();
      test_load_ext();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
MEM-stage load/store unit between the EX/MEM and MEM/WB pipeline registers.
- Turns the EX/MEM access into a byte-enabled, word-aligned request/ready transaction on the data-memory bus.
- Stalls the pipeline until the transaction completes.
- Returns a sign- or zero-extended dataout_MEM for the MEM/WB register.
- Flags misaligned and illegal accesses.

Parameters:
- TIMEOUT, 15: max dmem_ready wait cycles; used only with LSU_TIMEOUT_EN.
- TW, 4: timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- MemRead_MEM  in  1  load request from EX/MEM
- MemWrite_MEM  in  1  store request from EX/MEM
- funct3_MEM  in  3  access size/sign (RV32I encoding)
- aluout_MEM  in  32  effective byte address
- rs2data_MEM  in  32  store data
- dataout_MEM  out  32  extended load result, to MEM/WB
- stall_MEM  out  1  freeze PC/IF/ID/EX/MEM registers
- misalign_MEM  out  1  access misaligned or illegal; access suppressed
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  bus completes the access this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready = 1
- bus_err_MEM  out  1  timeout abort; tied 0 without LSU_TIMEOUT_EN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - dmem_req, dmem_we = 0; dmem_be = 0; dmem_addr, dmem_wdata = 0.
  - dataout_MEM = 0, bus_err_MEM = 0.
  - Timeout counter = 0.
  - Asserting rst mid-transaction drops dmem_req immediately and abandons the access.
- Access valid: access = MemRead_MEM | MemWrite_MEM.
- Illegal cases:
  - Misaligned: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - MemRead_MEM and MemWrite_MEM both 1.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Legal access: stall_MEM = 1 (combinational). Register dmem_addr = {addr[31:2], 2'b00}, dmem_be, dmem_wdata and dmem_we. Go to BUSY.
  - Illegal access: misalign_MEM = 1 (combinational), stall_MEM = 0, no bus request, dataout_MEM = 0. Stay in IDLE.
- BUSY:
  - dmem_req = 1 and stall_MEM = 1.
  - Address, enables and data stay stable until dmem_ready.
  - On dmem_ready: for a load, register the extracted data into dataout_MEM. Drop dmem_req next cycle. Go to DONE.
- DONE:
  - stall_MEM = 0 and dataout_MEM held.
  - The pipeline advances at the end of this cycle. Go to IDLE unconditionally.
  - A new access arriving in the next cycle is handled from IDLE.
- Latency: minimum 3 cycles per memory instruction (IDLE, BUSY with ready, DONE). Each extra BUSY cycle adds 1.
- Non-memory instruction: stall_MEM = 0, dataout_MEM holds its last value, no bus activity.
- Store byte lanes, with o = addr[1:0]:
  - SB: be = 4'b0001 << o, wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << o, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
- Loads: dmem_be = 4'b1111.
- Load extraction:
  - Select byte at o or half at o[1]; o is registered in IDLE.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- dmem_ready outside BUSY is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - BUSY increments a TW-bit counter each cycle without dmem_ready.
  - When the counter reaches TIMEOUT: drop dmem_req, set dataout_MEM = 0, go to DONE with bus_err_MEM = 1 for that one cycle.
  - The counter clears on entering BUSY.
- Undefined: no counter; BUSY waits indefinitely; bus_err_MEM = 0.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - State encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- Sub-module lsu_align, purely combinational:
  - Store path: (funct3, offset, rs2) -> (be, wdata).
  - Load path: (funct3, offset, rdata) -> extended data.
  - Also produces the legal/misaligned check.
- The FSM, registers and timeout stay in mem_lsu.

Test Plan:
1. LW addr 0x100, dmem_ready in the first BUSY cycle, rdata 0xDEADBEEF:
   - stall_MEM = 1,1,0 over 3 cycles; dmem_addr 0x100; be 1111.
   - dataout_MEM 0xDEADBEEF in DONE.
2. LB addr 0x103, rdata 0x80FF_1234 -> dataout_MEM 0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
3. SH addr 0x202, rs2 0x0000_ABCD -> dmem_we 1, dmem_addr 0x200, be 1100, wdata 0xABCD_ABCD.
4. LW addr 0x101 -> misalign_MEM 1, stall_MEM 0, dmem_req never asserted, dataout_MEM 0.
5. SB with dmem_ready delayed 5 cycles:
   - req/addr/be/wdata stable for all 5 cycles; stall_MEM held.
   - rst pulsed mid-BUSY on a second run -> dmem_req 0 and state IDLE immediately.
6. With LSU_TIMEOUT_EN, TIMEOUT=15, dmem_ready never asserted -> after 15 BUSY cycles dmem_req 0, one-cycle bus_err_MEM 1, dataout_MEM 0, stall released.
